// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: FETCH/EXEC1/EXEC2 sequencing with bus stalls,
// a fixed-length mult/div wait phase, sub-word byte lanes and a terminal HALTED state.

package mips_control_pkg;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_BLEZ    = 6'h06,
        OP_BGTZ    = 6'h07,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LB      = 6'h20,
        OP_LH      = 6'h21,
        OP_LW      = 6'h23,
        OP_LBU     = 6'h24,
        OP_LHU     = 6'h25,
        OP_SB      = 6'h28,
        OP_SH      = 6'h29,
        OP_SW      = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'h00,
        FN_SRL   = 6'h02,
        FN_SRA   = 6'h03,
        FN_SLLV  = 6'h04,
        FN_SRLV  = 6'h06,
        FN_SRAV  = 6'h07,
        FN_JR    = 6'h08,
        FN_JALR  = 6'h09,
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1A,
        FN_DIVU  = 6'h1B,
        FN_ADD   = 6'h20,
        FN_ADDU  = 6'h21,
        FN_SUB   = 6'h22,
        FN_SUBU  = 6'h23,
        FN_AND   = 6'h24,
        FN_OR    = 6'h25,
        FN_XOR   = 6'h26,
        FN_NOR   = 6'h27,
        FN_SLT   = 6'h2A,
        FN_SLTU  = 6'h2B
    } func_t;

    typedef enum logic {
        REG_RT = 1'b0,
        REG_RD = 1'b1
    } regfile_addr_sel_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC1  = 3'd1,
        EXEC2  = 3'd2,
        MULDIV = 3'd3,
        HALTED = 3'd4
    } state_t;

endpackage

module mips_control_fsm
    import mips_control_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  opcode_t           opcode_i,
    input  func_t             function_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              waitrequest_i,
    input  logic              next_pc_zero_i,
    output logic [2:0]        state_o,
    output logic              active_o,
    output logic              pc_write_en_o,
    output logic              ir_write_en_o,
    output logic              ram_write_en_o,
    output logic              ram_read_en_o,
    output logic [3:0]        ram_byte_en_o,
    output logic              ram_addr_sel_o,
    output logic              src_b_sel_o,
    output logic              regfile_write_en_o,
    output regfile_addr_sel_t regfile_addr_3_sel_o,
    output logic              hi_lo_write_en_o,
    output logic              muldiv_start_o
);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [7:0] COUNT_LOAD = 8'(MULDIV_LATENCY - 1);

    state_t     state;
    logic [7:0] count;
    logic       ir_loaded;

    logic       is_load;
    logic       is_store;
    logic       is_imm_alu;
    logic       is_rd_write;
    logic       is_hi_lo_move;
    logic       is_muldiv;
    logic [1:0] access_size;
    logic [3:0] lanes;

    // Instruction class decode; anything not listed only advances the PC.
    always_comb begin
        is_load       = 1'b0;
        is_store      = 1'b0;
        is_imm_alu    = 1'b0;
        is_rd_write   = 1'b0;
        is_hi_lo_move = 1'b0;
        is_muldiv     = 1'b0;
        access_size   = SIZE_WORD;
        case (opcode_i)
            OP_LB, OP_LBU: begin
                is_load     = 1'b1;
                access_size = SIZE_BYTE;
            end
            OP_LH, OP_LHU: begin
                is_load     = 1'b1;
                access_size = SIZE_HALF;
            end
            OP_LW: is_load = 1'b1;
            OP_SB: begin
                is_store    = 1'b1;
                access_size = SIZE_BYTE;
            end
            OP_SH: begin
                is_store    = 1'b1;
                access_size = SIZE_HALF;
            end
            OP_SW: is_store = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: is_imm_alu = 1'b1;
            OP_SPECIAL: begin
                case (function_i)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_MFHI, FN_MFLO,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: is_rd_write = 1'b1;
                    FN_MTHI, FN_MTLO: is_hi_lo_move = 1'b1;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_muldiv = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Misaligned addresses are not trapped; lanes simply follow the offset.
    always_comb begin
        case (access_size)
            SIZE_WORD: lanes = 4'b1111;
            SIZE_HALF: lanes = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            default:   lanes = 4'b0001 << addr_lo_i;
        endcase
    end

    always_comb begin
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        ram_write_en_o       = 1'b0;
        ram_read_en_o        = 1'b0;
        ram_byte_en_o        = 4'b0000;
        ram_addr_sel_o       = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_write_en_o   = 1'b0;
        regfile_addr_3_sel_o = REG_RT;
        hi_lo_write_en_o     = 1'b0;
        muldiv_start_o       = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ram_read_en_o = 1'b1;
                    ram_byte_en_o = 4'b1111;
                end
                EXEC1: begin
                    ir_write_en_o = !ir_loaded;
                    if (is_load) begin
                        ram_read_en_o  = 1'b1;
                        ram_addr_sel_o = 1'b1;
                        src_b_sel_o    = 1'b1;
                        ram_byte_en_o  = lanes;
                    end
                end
                EXEC2: begin
                    if (is_store) begin
                        ram_write_en_o = 1'b1;
                        ram_addr_sel_o = 1'b1;
                        src_b_sel_o    = 1'b1;
                        ram_byte_en_o  = lanes;
                        pc_write_en_o  = !waitrequest_i;
                    end else if (is_load) begin
                        regfile_write_en_o = 1'b1;
                        pc_write_en_o      = 1'b1;
                    end else if (is_imm_alu) begin
                        regfile_write_en_o = 1'b1;
                        src_b_sel_o        = 1'b1;
                        pc_write_en_o      = 1'b1;
                    end else if (is_rd_write) begin
                        regfile_write_en_o   = 1'b1;
                        regfile_addr_3_sel_o = REG_RD;
                        pc_write_en_o        = 1'b1;
                    end else if (is_hi_lo_move) begin
                        hi_lo_write_en_o = 1'b1;
                        pc_write_en_o    = 1'b1;
                    end else if (is_muldiv) begin
                        muldiv_start_o = 1'b1;
                    end else begin
                        pc_write_en_o = 1'b1;
                    end
                end
                MULDIV: begin
                    if (count == 8'd0) begin
                        hi_lo_write_en_o = 1'b1;
                        pc_write_en_o    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o  = state;
    assign active_o = !reset && (state != HALTED);

    // Every PC write checks for a zero target, so a stalled store defers the halt too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            count     <= 8'd0;
            ir_loaded <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir_loaded <= 1'b0;
                    if (!waitrequest_i) state <= EXEC1;
                end
                EXEC1: begin
                    ir_loaded <= 1'b1;
                    if (!(is_load && waitrequest_i)) state <= EXEC2;
                end
                EXEC2: begin
                    if (is_muldiv) begin
                        count <= COUNT_LOAD;
                        state <= MULDIV;
                    end else if (pc_write_en_o) begin
                        state <= next_pc_zero_i ? HALTED : FETCH;
                    end
                end
                MULDIV: begin
                    if (count == 8'd0) begin
                        state <= next_pc_zero_i ? HALTED : FETCH;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: per-instruction cycle traces are built from the
// instruction-class rules and compared against every output each cycle.

module tb_mips_control_fsm;
    import mips_control_pkg::*;

    localparam int LAT   = 4;
    localparam int EXP_W = 18;

    localparam int C_LOAD   = 0;
    localparam int C_STORE  = 1;
    localparam int C_IMM    = 2;
    localparam int C_RD     = 3;
    localparam int C_HILO   = 4;
    localparam int C_MULDIV = 5;
    localparam int C_OTHER  = 6;

    typedef struct packed {
        logic [2:0] st;
        logic       active;
        logic       pc_we;
        logic       ir_we;
        logic       ram_we;
        logic       ram_re;
        logic [3:0] be;
        logic       addr_sel;
        logic       src_b;
        logic       rf_we;
        logic       rf_sel;
        logic       hilo_we;
        logic       start;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       wr;
        logic       npz;
        logic [1:0] alo;
        logic [5:0] op;
        logic [5:0] fn;
    } stim_t;

    logic              clk = 1'b0;
    logic              reset;
    opcode_t           opcode_i;
    func_t             function_i;
    logic [1:0]        addr_lo_i;
    logic              waitrequest_i;
    logic              next_pc_zero_i;
    logic [2:0]        state_o;
    logic              active_o;
    logic              pc_write_en_o;
    logic              ir_write_en_o;
    logic              ram_write_en_o;
    logic              ram_read_en_o;
    logic [3:0]        ram_byte_en_o;
    logic              ram_addr_sel_o;
    logic              src_b_sel_o;
    logic              regfile_write_en_o;
    regfile_addr_sel_t regfile_addr_3_sel_o;
    logic              hi_lo_write_en_o;
    logic              muldiv_start_o;

    logic [EXP_W-1:0] exp_q[$];
    stim_t            stim_q[$];
    int               checks = 0;
    int               errors = 0;

    int op_tab[23] = '{0, 0, 0, 0, 1, 2, 3, 4, 8, 9, 10, 11, 12, 13, 14, 15,
                       32, 33, 35, 36, 37, 40, 41};
    int fn_tab[22] = '{0, 2, 3, 4, 7, 8, 9, 16, 17, 18, 19, 24, 25, 26, 27,
                       32, 33, 34, 36, 39, 42, 43};

    always #5 clk = ~clk;

    mips_control_fsm #(.MULDIV_LATENCY(LAT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .opcode_i             (opcode_i),
        .function_i           (function_i),
        .addr_lo_i            (addr_lo_i),
        .waitrequest_i        (waitrequest_i),
        .next_pc_zero_i       (next_pc_zero_i),
        .state_o              (state_o),
        .active_o             (active_o),
        .pc_write_en_o        (pc_write_en_o),
        .ir_write_en_o        (ir_write_en_o),
        .ram_write_en_o       (ram_write_en_o),
        .ram_read_en_o        (ram_read_en_o),
        .ram_byte_en_o        (ram_byte_en_o),
        .ram_addr_sel_o       (ram_addr_sel_o),
        .src_b_sel_o          (src_b_sel_o),
        .regfile_write_en_o   (regfile_write_en_o),
        .regfile_addr_3_sel_o (regfile_addr_3_sel_o),
        .hi_lo_write_en_o     (hi_lo_write_en_o),
        .muldiv_start_o       (muldiv_start_o)
    );

    // ---------------- reference model ----------------

    function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                     output int cat, output int width);
        cat   = C_OTHER;
        width = 0;
        case (op)
            6'h20, 6'h24: begin cat = C_LOAD;  width = 1; end
            6'h21, 6'h25: begin cat = C_LOAD;  width = 2; end
            6'h23:        begin cat = C_LOAD;  width = 4; end
            6'h28:        begin cat = C_STORE; width = 1; end
            6'h29:        begin cat = C_STORE; width = 2; end
            6'h2B:        begin cat = C_STORE; width = 4; end
            default: begin
                if (op >= 6'h08 && op <= 6'h0F) cat = C_IMM;
                else if (op == 6'h00) begin
                    if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12})
                        cat = C_RD;
                    else if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B)
                        cat = C_RD;
                    else if (fn == 6'h11 || fn == 6'h13)
                        cat = C_HILO;
                    else if (fn >= 6'h18 && fn <= 6'h1B)
                        cat = C_MULDIV;
                end
            end
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input int width, input logic [1:0] a);
        int shift;
        int mask;
        shift = (width == 4) ? 0 : (width == 2) ? (int'(a) & 2) : int'(a);
        mask  = ((1 << width) - 1) << shift;
        return 4'(mask);
    endfunction

    function automatic exp_t idle(input state_t st);
        exp_t e;
        e        = '0;
        e.st     = st;
        e.active = (st != HALTED);
        return e;
    endfunction

    function automatic stim_t rand_stim(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [1:0] alo);
        stim_t s;
        s.rst = 1'b0;
        s.wr  = 1'($urandom_range(0, 1));
        s.npz = 1'($urandom_range(0, 1));
        s.alo = alo;
        s.op  = op;
        s.fn  = fn;
        return s;
    endfunction

    task automatic add(input exp_t e, input stim_t s);
        exp_q.push_back(e);
        stim_q.push_back(s);
    endtask

    task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] alo,
                               input int nf, input int n1, input int n2, input bit halt);
        int cat, width, n1e, n2e;
        logic [3:0] lanes;
        exp_t e;
        stim_t s;
        classify(op, fn, cat, width);
        lanes = lane_mask(width, alo);
        for (int i = 0; i <= nf; i++) begin
            e        = idle(FETCH);
            e.ram_re = 1'b1;
            e.be     = 4'hF;
            s        = rand_stim(op, fn, alo);
            s.wr     = (i < nf);
            add(e, s);
        end
        n1e = (cat == C_LOAD) ? n1 : 0;
        for (int i = 0; i <= n1e; i++) begin
            e       = idle(EXEC1);
            e.ir_we = (i == 0);
            s       = rand_stim(op, fn, alo);
            if (cat == C_LOAD) begin
                e.ram_re   = 1'b1;
                e.addr_sel = 1'b1;
                e.src_b    = 1'b1;
                e.be       = lanes;
                s.wr       = (i < n1e);
            end
            add(e, s);
        end
        n2e = (cat == C_STORE) ? n2 : 0;
        for (int i = 0; i <= n2e; i++) begin
            e = idle(EXEC2);
            s = rand_stim(op, fn, alo);
            case (cat)
                C_STORE: begin
                    e.ram_we   = 1'b1;
                    e.addr_sel = 1'b1;
                    e.src_b    = 1'b1;
                    e.be       = lanes;
                    e.pc_we    = (i == n2e);
                    s.wr       = (i < n2e);
                end
                C_LOAD:   begin e.rf_we = 1'b1; e.pc_we = 1'b1; end
                C_IMM:    begin e.rf_we = 1'b1; e.src_b = 1'b1; e.pc_we = 1'b1; end
                C_RD:     begin e.rf_we = 1'b1; e.rf_sel = 1'b1; e.pc_we = 1'b1; end
                C_HILO:   begin e.hilo_we = 1'b1; e.pc_we = 1'b1; end
                C_MULDIV: e.start = 1'b1;
                default:  e.pc_we = 1'b1;
            endcase
            if (e.pc_we) s.npz = halt;
            add(e, s);
        end
        if (cat == C_MULDIV) begin
            for (int i = 0; i < LAT; i++) begin
                e = idle(MULDIV);
                s = rand_stim(op, fn, alo);
                if (i == LAT - 1) begin
                    e.hilo_we = 1'b1;
                    e.pc_we   = 1'b1;
                    s.npz     = halt;
                end
                add(e, s);
            end
        end
    endtask

    task automatic add_halted(input int n);
        for (int i = 0; i < n; i++)
            add(idle(HALTED), rand_stim(6'($urandom), 6'($urandom), 2'($urandom)));
    endtask

    task automatic add_reset(input state_t cur);
        exp_t e;
        stim_t s;
        e        = idle(cur);
        e.active = 1'b0;
        s        = rand_stim(6'($urandom), 6'($urandom), 2'($urandom));
        s.rst    = 1'b1;
        add(e, s);
    endtask

    // ---------------- driver ----------------

    task automatic drive_cycle(input stim_t s, output exp_t o);
        reset          = s.rst;
        waitrequest_i  = s.wr;
        next_pc_zero_i = s.npz;
        addr_lo_i      = s.alo;
        opcode_i       = opcode_t'(s.op);
        function_i     = func_t'(s.fn);
        @(negedge clk);
        o.st       = state_o;
        o.active   = active_o;
        o.pc_we    = pc_write_en_o;
        o.ir_we    = ir_write_en_o;
        o.ram_we   = ram_write_en_o;
        o.ram_re   = ram_read_en_o;
        o.be       = ram_byte_en_o;
        o.addr_sel = ram_addr_sel_o;
        o.src_b    = src_b_sel_o;
        o.rf_we    = regfile_write_en_o;
        o.rf_sel   = regfile_addr_3_sel_o;
        o.hilo_we  = hi_lo_write_en_o;
        o.start    = muldiv_start_o;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        exp_t o, e;
        reset          = 1'b1;
        waitrequest_i  = 1'b0;
        next_pc_zero_i = 1'b0;
        addr_lo_i      = 2'd0;
        opcode_i       = OP_SPECIAL;
        function_i     = FN_SLL;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e        = idle(FETCH);
            e.active = 1'b0;
            drive_cycle(rand_stim(6'($urandom), 6'($urandom), 2'($urandom)) | stim_t'({1'b1, 16'h0}), o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_addiu();
        exp_t o, e;
        stim_t s;
        int n = 0;
        build_instr(6'h09, 6'($urandom), 2'($urandom), 0, 0, 0, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL addiu cycle %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_load_stall();
        exp_t o, e;
        stim_t s;
        int n = 0;
        build_instr(6'h20, 6'($urandom), 2'd2, 1, 2, 0, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lb_stall cycle %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_store_stall();
        exp_t o, e;
        stim_t s;
        int n = 0;
        build_instr(6'h29, 6'($urandom), 2'd2, 0, 0, 1, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sh_stall cycle %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_mult();
        exp_t o, e;
        stim_t s;
        int n = 0;
        build_instr(6'h00, 6'h18, 2'($urandom), 0, 0, 0, 1'b0);
        if (stim_q.size() != 3 + LAT) begin
            errors++;
            $display("FAIL mult_latency: got %0d expected %0d", stim_q.size(), 3 + LAT);
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mult cycle %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_halt();
        exp_t o, e;
        stim_t s;
        int n = 0;
        build_instr(6'h00, 6'h08, 2'($urandom), 0, 0, 0, 1'b1);
        add_halted(10);
        add_reset(HALTED);
        build_instr(6'h09, 6'h00, 2'd0, 0, 0, 0, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jr_halt cycle %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_in_muldiv();
        exp_t o, e;
        stim_t s;
        int n = 0;
        build_instr(6'h00, 6'h1A, 2'($urandom), 0, 0, 0, 1'b0);
        while (stim_q.size() > 4) begin
            void'(stim_q.pop_back());
            void'(exp_q.pop_back());
        end
        add_reset(MULDIV);
        build_instr(6'h00, 6'h21, 2'($urandom), 0, 0, 0, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_muldiv cycle %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_lanes();
        exp_t o, e;
        stim_t s;
        int n = 0;
        logic [5:0] ops[6] = '{6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28};
        foreach (ops[k])
            for (int a = 0; a < 4; a++)
                build_instr(ops[k], 6'($urandom), 2'(a), 0,
                            $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lanes cycle %0d op %h alo %0d: got %b expected %b",
                         n, s.op, s.alo, o, e);
            end
            n++;
        end
    endtask

    task automatic test_random();
        exp_t o, e;
        stim_t s;
        int n = 0;
        logic [5:0] op, fn;
        bit halt;
        for (int k = 0; k < 150; k++) begin
            op   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(op_tab[$urandom_range(0, 22)]);
            fn   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(fn_tab[$urandom_range(0, 21)]);
            halt = ($urandom_range(0, 9) == 0);
            build_instr(op, fn, 2'($urandom), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3), halt);
            if (halt) begin
                add_halted($urandom_range(1, 3));
                add_reset(HALTED);
            end
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_t'(exp_q.pop_front());
            drive_cycle(s, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random cycle %0d op %h fn %h: got %b expected %b",
                         n, s.op, s.fn, o, e);
            end
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addiu();
        test_load_stall();
        test_store_stall();
        test_mult();
        test_halt();
        test_reset_in_muldiv();
        test_lanes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multi-cycle MIPS control unit that owns its own state register. It sequences FETCH/EXEC1/EXEC2 and stalls on bus `waitrequest_i`. It adds a parametrised multiply/divide wait phase, per-address byte enables for sub-word loads and stores, and a terminal HALTED state. It sits between the instruction register/decoder and the datapath, and drives every write-enable and mux select.

## Interface
- `MULDIV_LATENCY`, default 32: cycles spent in MULDIV waiting for the mult/div unit; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; sampled on `clk` rising edge.
- `opcode_i`  in  6  `opcode_t` of the current IR.
- `function_i`  in  6  `func_t` of the current IR.
- `addr_lo_i`  in  2  effective address bits [1:0] from the ALU (valid in EXEC1/EXEC2).
- `waitrequest_i`  in  1  bus stall; the current bus transfer must be held.
- `next_pc_zero_i`  in  1  the PC value about to be written is 0.
- `state_o`  out  3  current state: FETCH, EXEC1, EXEC2, MULDIV, HALTED.
- `active_o`  out  1  high unless in HALTED.
- `pc_write_en_o`, `ir_write_en_o`, `ram_write_en_o`, `ram_read_en_o`  out  1 each.
- `ram_byte_en_o`  out  4  byte lanes; lane k = address offset k.
- `ram_addr_sel_o`  out  1  0 = PC, 1 = ALU result.
- `src_b_sel_o`  out  1  0 = rt, 1 = immediate.
- `regfile_write_en_o`  out  1.
- `regfile_addr_3_sel_o`  out  `regfile_addr_sel_t`  RT or RD.
- `hi_lo_write_en_o`  out  1  HI/LO register write.
- `muldiv_start_o`  out  1  one-cycle start pulse to the mult/div unit.

## Operation
- **FETCH:**
  - Drive `ram_read_en_o` = 1, `ram_byte_en_o` = 1111, `ram_addr_sel_o` = 0.
  - Stay while `waitrequest_i`; otherwise go to EXEC1.
- **EXEC1:**
  - `ir_write_en_o` = 1 only in the first EXEC1 cycle. An internal `ir_loaded` flag is set at the end of that cycle and cleared in FETCH.
  - LW/LH/LHU/LB/LBU: drive `ram_read_en_o`, `src_b_sel_o`, `ram_addr_sel_o` and lane enables. Stay while `waitrequest_i`.
  - All other instructions go to EXEC2 unconditionally.
- **EXEC2:**
  - SW/SH/SB: drive `ram_write_en_o`, `src_b_sel_o`, `ram_addr_sel_o` and lane enables. Stay while `waitrequest_i`. `pc_write_en_o` is asserted only in the non-stalled cycle.
  - Loads: `regfile_write_en_o`, RT.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI: `regfile_write_en_o`, `src_b_sel_o`, RT.
  - SPECIAL ALU, shifts, MFHI/MFLO: `regfile_write_en_o`, RD.
  - MTHI/MTLO: `hi_lo_write_en_o`.
  - MULT/MULTU/DIV/DIVU: `muldiv_start_o` = 1, load counter with `MULDIV_LATENCY`-1, go to MULDIV, no `pc_write_en_o`.
  - Every other case asserts `pc_write_en_o` and goes to FETCH.
  - Undefined opcodes or functions: only `pc_write_en_o`.
- **MULDIV:**
  - Decrement the counter each cycle.
  - At counter 0: `hi_lo_write_en_o` = 1, `pc_write_en_o` = 1, go to FETCH.
- **Halt:** in any cycle where `pc_write_en_o` = 1 and `next_pc_zero_i` = 1, the next state is HALTED instead of FETCH. HALTED drives all strobes to 0 and `active_o` = 0, and is left only by `reset`.
- **Byte lanes:**
  - Word accesses: 1111.
  - Half accesses: 0011 if `addr_lo_i[1]` = 0, else 1100.
  - Byte accesses: 0001 << `addr_lo_i`.
  - Misaligned word/half addresses are not checked; lanes follow the rule above.
- **Counter:** 8 bits, unsigned. `MULDIV_LATENCY` = 1 gives exactly one MULDIV cycle.

## Timing
- **Reset:** state ← FETCH, counter ← 0, `ir_loaded` ← 0. While `reset` is high all strobes are 0, `ram_byte_en_o` = 0000 and `active_o` = 0. The first FETCH strobe appears in the cycle after `reset` falls.
- **Outputs:** combinational from state, `ir_loaded`, opcode/function, `addr_lo_i` and `waitrequest_i`. No registered output delay.
- **Instruction latency with zero wait:**
  - 3 cycles for most instructions.
  - MULT/DIV: 3 + `MULDIV_LATENCY` cycles.
  - Each stalled cycle adds exactly one.
- **Simultaneous events:**
  - `waitrequest_i` in EXEC2 on a store: the halt check is deferred to the non-stalled cycle.
  - Reset in any state, including MULDIV or HALTED, wins and aborts the instruction. No write strobe is issued during the reset cycle.
- Only one of `ram_read_en_o` / `ram_write_en_o` is high in any cycle.

## Test plan
- **Reset then ADDIU, `waitrequest_i` = 0:**
  - Cycle 1: FETCH with read_en = 1, byte_en = 1111.
  - Cycle 2: EXEC1 with ir_write_en = 1.
  - Cycle 3: EXEC2 with regfile_write_en = 1, src_b_sel = 1, pc_write_en = 1.
- **LB with `addr_lo_i` = 2, `waitrequest_i` high for 2 EXEC1 cycles:**
  - EXEC1 lasts 3 cycles with byte_en = 0100 throughout.
  - ir_write_en is high in the first cycle only.
  - EXEC2 then writes rt.
- **SH with `addr_lo_i` = 2, one wait cycle in EXEC2:**
  - write_en high for 2 cycles with byte_en = 1100.
  - pc_write_en high only in the second cycle.
- **MULT with `MULDIV_LATENCY` = 4:**
  - muldiv_start pulses once in EXEC2.
  - 4 MULDIV cycles follow; hi_lo_write_en and pc_write_en are high in the 4th.
  - Total latency 7 cycles.
- **JR with `next_pc_zero_i` = 1 in EXEC2:**
  - State goes to HALTED, active_o = 0, all strobes 0 for 10 cycles.
  - A reset pulse returns to FETCH.
- **Reset asserted in MULDIV cycle 2:**
  - No hi_lo_write_en or pc_write_en is issued.
  - state_o = FETCH after the reset cycle.
